// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types, default sizes and helpers for the data-memory
//            line controller and its storage array.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // Default geometry: 256-bit lines, 512 lines, 10-cycle access, 32-byte lines
  localparam int DEF_LINE_BITS   = 256;
  localparam int DEF_DEPTH       = 512;
  localparam int DEF_LATENCY     = 10;
  localparam int DEF_OFFSET_BITS = 5;

  // Latency counter width; covers the full 2..255 latency range
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Ceiling log2 used to size the line index
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_array
// Purpose  : Single-port line storage with synchronous write and a registered
//            read port. The array is named memory[] so benches can preload
//            and inspect it hierarchically; it is never cleared by reset.
// Revision : 1.0  initial release
// ============================================================================
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int IDX_W     = clog2(DEF_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [LINE_BITS-1:0] memory [DEPTH];
  logic [LINE_BITS-1:0] rdata_q;
  logic [LINE_BITS-1:0] rdata_d;

  // Line write; storage contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) memory[idx_i] <= wdata_i;
  end

  // Read register holds its value until the next read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en_i) rdata_d = memory[idx_i];
  end

  // Read register, cleared so data_o is defined from reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_ctrl
// Purpose  : Fixed-latency line refill / write-back controller in front of
//            the line array. One access in flight; ack_o pulses for one cycle
//            and at least one idle cycle follows every ack.
// Revision : 1.0  initial release
// ============================================================================
module dmem_line_ctrl
  import dmem_pkg::*;
#(
  parameter int LINE_BITS   = DEF_LINE_BITS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  output logic [LINE_BITS-1:0] data_o,
  output logic                 ack_o,
  output logic                 busy_o
);

  localparam int               IDX_W      = clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 write_q, write_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;

  logic                 rd_en;
  logic                 wr_en;

  // Offset bits and index bits above the array size do not select a line
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

  // Next-state logic: accept in IDLE, count down in WAIT, one-cycle ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_WAIT;
          cnt_d   = C_CNT_LOAD;
          write_d = write_i;
          idx_d   = addr_i[OFFSET_BITS +: IDX_W];
          wdata_d = data_i;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and latched request; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Read is issued on the last WAIT cycle so data lands on the edge into ACK;
  // write commits on the edge leaving ACK, before the idle bubble
  assign rd_en  = (state_q == ST_WAIT) && (cnt_q == C_CNT_ONE) && !write_q;
  assign wr_en  = (state_q == ST_ACK) && write_q;
  assign ack_o  = (state_q == ST_ACK);
  assign busy_o = (state_q != ST_IDLE);

  dmem_line_array #(
    .LINE_BITS (LINE_BITS),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rd_en_i (rd_en),
    .wr_en_i (wr_en),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_line_ctrl
// Purpose  : Self-checking bench for dmem_line_ctrl: transaction-level model
//            with timestamped completion, per-cycle output compare, directed
//            scenarios with literal expectations and a randomized phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_line_ctrl;

  localparam int LB  = 256;
  localparam int DEP = 512;
  localparam int LAT = 10;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          wr;
  logic [31:0]   addr;
  logic [LB-1:0] din;
  logic [LB-1:0] data_o;
  logic          ack_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;

  dmem_line_ctrl #(
    .LINE_BITS   (LB),
    .DEPTH       (DEP),
    .LATENCY     (LAT),
    .OFFSET_BITS (5)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .write_i (wr),
    .addr_i  (addr),
    .data_i  (din),
    .data_o  (data_o),
    .ack_o   (ack_o),
    .busy_o  (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [LB-1:0] rand256();
    logic [LB-1:0] v;
    for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  // Each accepted access is a record with the edge number at which it must
  // acknowledge; the line store is a plain array updated one edge later.
  logic [LB-1:0] mem_m [DEP];
  int            cyc     = 0;
  bit            pend    = 0;
  bit            p_wr    = 0;
  int            p_idx   = 0;
  logic [LB-1:0] p_data  = '0;
  int            ack_at  = 0;
  logic [LB-1:0] m_data  = '0;
  bit            exp_ack  = 0;
  bit            exp_busy = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pend   = 0;
        m_data = '0;
      end else if (pend && cyc == ack_at + 1) begin
        if (p_wr) mem_m[p_idx] = p_data;
        pend = 0;
      end else if (pend && cyc == ack_at) begin
        if (!p_wr) m_data = mem_m[p_idx];
      end else if (!pend && req) begin
        pend   = 1;
        p_wr   = wr;
        p_idx  = int'((addr / 32) % DEP);
        p_data = din;
        ack_at = cyc + LAT - 1;
      end
      exp_ack  = pend && (cyc == ack_at);
      exp_busy = pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("ack_in_reset",  {255'd0, ack_o},  '0);
        chk("busy_in_reset", {255'd0, busy_o}, '0);
        chk("data_in_reset", data_o,           '0);
      end else begin
        chk("ack",  {255'd0, ack_o},  {255'd0, exp_ack});
        chk("busy", {255'd0, busy_o}, {255'd0, exp_busy});
        chk("data", data_o, m_data);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one access from the current (negedge) time; returns negedges to ack,
  // number of busy cycles seen and data_o in the ack cycle.
  task automatic access(input bit w, input logic [31:0] a, input logic [LB-1:0] d,
                        input bit wiggle, output int lat, output int busy_n,
                        output logic [LB-1:0] rd);
    req = 1'b1; wr = w; addr = a; din = d;
    lat = 0; busy_n = 0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
      if (ack_o) begin
        lat = n;
        rd  = data_o;
        break;
      end
      if (wiggle && busy_o) begin
        req  = 1'($urandom_range(0, 1));
        wr   = 1'($urandom_range(0, 1));
        addr = $urandom;
        din  = rand256();
      end
    end
    if (lat == 0) chk("access_timeout", 256'd0, 256'd1);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 30; n++) begin
      if (!busy_o) return;
      @(negedge clk);
    end
    chk("idle_timeout", {255'd0, busy_o}, '0);
  endtask

  // ---------------- stimulus ----------------
  int            lat_a, lat_b, bn;
  logic [LB-1:0] rd_a, rd_b, d1, old3;
  int            ackq[$];
  int            consec;
  bit            prev;

  initial begin
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < DEP; i++) begin
      mem_m[i]             = rand256();
      dut.u_array.memory[i] = mem_m[i];
    end
    mem_m[0] = 256'd5;      dut.u_array.memory[0] = 256'd5;
    old3     = 256'h3333;
    mem_m[3] = old3;        dut.u_array.memory[3] = old3;

    idle(3);
    chk("reset_ack",  {255'd0, ack_o},  '0);
    chk("reset_busy", {255'd0, busy_o}, '0);
    chk("reset_data", data_o,           '0);
    #2 rst_n = 1'b1;
    idle(2);

    // Read of preloaded line 0
    access(1'b0, 32'h0, '0, 1'b0, lat_a, bn, rd_a);
    chk("read0_latency", 256'(lat_a), 256'd10);
    chk("read0_busy",    256'(bn),    256'd10);
    chk("read0_data",    rd_a,        256'd5);

    // Write then immediately read the same line
    idle(2);
    access(1'b1, 32'h20, 256'hDEADBEEF, 1'b0, lat_a, bn, rd_a);
    access(1'b0, 32'h20, '0,            1'b0, lat_b, bn, rd_b);
    chk("wr_latency",   256'(lat_a),         256'd10);
    chk("raw_latency",  256'(lat_b),         256'd11);
    chk("raw_total",    256'(lat_a + lat_b), 256'd21);
    chk("raw_data",     rd_b,                256'hDEADBEEF);

    // Address wrap and misaligned address both map to line 0
    idle(2);
    access(1'b0, 32'h4000, '0, 1'b0, lat_a, bn, rd_a);
    chk("wrap_data", rd_a, 256'd5);
    idle(1);
    access(1'b0, 32'h1F, '0, 1'b0, lat_a, bn, rd_a);
    chk("offset_data", rd_a, 256'd5);

    // req held high: acks every LATENCY+1 cycles, never back to back
    idle(2);
    req = 1'b1; wr = 1'b0; addr = 32'h20;
    ackq.delete(); prev = 0; consec = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_o) begin
        ackq.push_back(n);
        if (prev) consec++;
      end
      prev = ack_o;
    end
    req = 1'b0;
    chk("hold_ack_count", 256'(ackq.size()), 256'd3);
    chk("hold_ack0", 256'((ackq.size() > 0) ? ackq[0] : 0), 256'd10);
    chk("hold_ack1", 256'((ackq.size() > 1) ? ackq[1] : 0), 256'd21);
    chk("hold_ack2", 256'((ackq.size() > 2) ? ackq[2] : 0), 256'd32);
    chk("hold_no_consecutive", 256'(consec), 256'd0);
    wait_idle();

    // Reset in cycle 5 of a write to line 3 aborts it
    idle(2);
    req = 1'b1; wr = 1'b1; addr = 32'h60; din = rand256();
    idle(5);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ack",  {255'd0, ack_o},  '0);
    chk("abort_busy", {255'd0, busy_o}, '0);
    chk("abort_data", data_o,           '0);
    idle(2);
    #2 rst_n = 1'b1;
    idle(1);
    access(1'b0, 32'h60, '0, 1'b0, lat_a, bn, rd_a);
    chk("abort_line3_old", rd_a, old3);

    // Inputs toggled during WAIT do not affect the latched access
    idle(2);
    d1 = rand256();
    access(1'b1, 32'h40, d1, 1'b1, lat_a, bn, rd_a);
    idle(1);
    access(1'b0, 32'h40, '0, 1'b1, lat_b, bn, rd_b);
    chk("wiggle_wr_latency", 256'(lat_a), 256'd10);
    chk("wiggle_readback",   rd_b,        d1);

    // Randomized traffic with occasional asynchronous resets
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 1'b0;
        idle(2);
        #2 rst_n = 1'b1;
      end else begin
        req  = ($urandom_range(0, 9) < 7);
        wr   = 1'($urandom_range(0, 1));
        addr = {$urandom_range(0, 3) == 0 ? $urandom : 32'd0} ^
               {18'd0, 4'($urandom_range(0, 15)), 5'd0, 5'($urandom_range(0, 31))};
        din  = rand256();
      end
    end
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
